alu_exec: RTL and testbench
===========================

ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter OPW, default 4, alu_op width.
REQ-003 SHALL have port clk input 1 as the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n input 1 as the reset; reset is asynchronous and active-low.
REQ-005 SHALL have port in_valid input 1, meaning an operation is presented.
REQ-006 SHALL have port in_ready output 1, meaning the block accepts an operation this cycle.
REQ-007 SHALL have port alu_op input OPW, the operation code (see REQ-012).
REQ-008 SHALL have port op_a input XLEN, operand A (RS1 value).
REQ-009 SHALL have port op_b input XLEN, operand B, taken from the ALUSrc2 extender output (RS2, ImmI, ImmS, ShamtI or ImmU).
REQ-010 SHALL have ports out_valid output 1, out_ready input 1, and result output XLEN, forming the result handshake.
REQ-011 SHALL have port zero output 1, meaning result == 0.

Function
REQ-012 SHALL decode alu_op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT signed, 6 SLTU unsigned, 7 SLL, 8 SRL, 9 SRA, 10 PASSB (LUI); codes 11-15 SHALL execute as ADD.
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 SHALL define accept as in_valid && in_ready; in_ready SHALL be 1 in IDLE, 1 in DONE when out_ready is 1, else 0.
REQ-015 On accept of a non-shift op, SHALL register the result and enter DONE; out_valid is 1 the following cycle (latency 1).
REQ-016 On accept of SLL/SRL/SRA, SHALL load op_a into the shift register and shamt = op_b[4:0] into a 5-bit down-counter; op_b[31:5] SHALL be ignored.
REQ-017 A shift with shamt 0 SHALL go directly to DONE with result = op_a (latency 1).
REQ-018 A shift with shamt nonzero SHALL enter SHIFT, shifting 1 bit per cycle and decrementing the counter, and SHALL enter DONE on the cycle the counter reaches 0 (latency 1+shamt, max 32).
REQ-019 SRA SHALL replicate bit XLEN-1 on each step; SRL/SLL SHALL fill zeros.
REQ-020 ADD/SUB SHALL wrap modulo 2^XLEN; SLT/SLTU SHALL produce 0 or 1 zero-extended.
REQ-021 In DONE, out_valid SHALL be 1 and result held stable until out_ready.
REQ-022 DONE with out_ready=1 and in_valid=0 SHALL return to IDLE.
REQ-023 DONE with out_ready=1 and in_valid=1 SHALL accept the new op in the same cycle (back-to-back, no bubble).
REQ-024 In SHIFT, in_valid SHALL be ignored (in_ready=0); out_valid SHALL be 0.
REQ-025 zero SHALL be a combinational function of registered result.
REQ-026 Operand inputs SHALL be sampled only on accept; later changes SHALL have no effect.

Reset
REQ-027 On rst_n=0, SHALL immediately force state IDLE, out_valid 0, result 0 (zero 1), counter 0, and shift register 0.
REQ-028 Reset during SHIFT or DONE SHALL discard the operation, with no out_valid pulse after release.
REQ-029 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-030 alu_op encodings, the state enum, and XLEN default SHALL reside in shared package alu_pkg.
REQ-031 The iterative shifter (shift register, counter, direction/arith control) SHALL be sub-module alu_iter_shifter; the remainder stays in alu_exec.

Verification
REQ-032 ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, out_valid 1 cycle after accept; SUB 5-5 -> result 0, zero=1.
REQ-033 SLT 0xFFFFFFFF vs 0x00000001 -> 1; SLTU with the same operands -> 0.
REQ-034 SRA op_a=0x80000000, op_b=0x0000001F -> result 0xFFFFFFFF after 32 cycles, in_ready 0 throughout SHIFT.
REQ-035 SLL op_b=0x00000020 (shamt 0) -> result = op_a after 1 cycle; PASSB op_b=0x12345000 -> 0x12345000.
REQ-036 out_ready held 0 for 3 cycles in DONE -> result stable, no accept; then out_ready=1 with in_valid=1 -> new op accepted that same cycle.
REQ-037 rst_n pulsed low mid-SHIFT (SRL shamt 10, cycle 4) -> out_valid 0, result 0 immediately; no later out_valid without a new accept.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU execute stage.
//   XLEN_DEF  - default datapath width
//   alu_op_e  - operation encodings for alu_op; codes above OP_PASSB run as ADD
//   state_e   - execute-stage FSM states
//   is_shift  - true for the operations handled by the iterative shifter
package alu_pkg;

    localparam int XLEN_DEF = 32;
    localparam int SHAMT_W  = 5;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLT   = 4'd5,
        OP_SLTU  = 4'd6,
        OP_SLL   = 4'd7,
        OP_SRL   = 4'd8,
        OP_SRA   = 4'd9,
        OP_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic logic is_shift(input alu_op_e op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_iter_shifter.sv
// alu_iter_shifter: one-bit-per-step shifter with a shift-amount down-counter.
//   clk, rst_n - clock, async active-low reset
//   load_i     - capture data_i, shamt_i and the direction/arith controls
//   step_i     - shift one bit and decrement the counter (ignored when counter is 0)
//   data_i     - value to shift
//   shamt_i    - number of single-bit steps
//   left_i     - 1: shift left, 0: shift right
//   arith_i    - right shifts replicate the MSB when 1, else fill zeros
//   next_o     - value the register will hold after the next step
//   cnt_o      - remaining step count
module alu_iter_shifter
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               step_i,
    input  logic [XLEN-1:0]    data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic               left_i,
    input  logic               arith_i,
    output logic [XLEN-1:0]    next_o,
    output logic [SHAMT_W-1:0] cnt_o
);

    logic [XLEN-1:0]    sh_q, sh_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               left_q, left_d;
    logic               arith_q, arith_d;

    assign next_o = left_q ? {sh_q[XLEN-2:0], 1'b0}
                           : {arith_q & sh_q[XLEN-1], sh_q[XLEN-1:1]};
    assign cnt_o  = cnt_q;

    always_comb begin
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        arith_d = arith_q;
        if (load_i) begin
            sh_d    = data_i;
            cnt_d   = shamt_i;
            left_d  = left_i;
            arith_d = arith_i;
        end else if (step_i && (cnt_q != '0)) begin
            sh_d  = next_o;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q    <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            arith_q <= arith_d;
        end
    end

endmodule

// File: rtl/alu_exec.sv
// alu_exec: ALU execute stage with valid/ready handshakes on both sides.
//   clk, rst_n          - clock, async active-low reset
//   in_valid / in_ready - operation handshake (alu_op, op_a, op_b sampled on accept)
//   alu_op              - operation code (alu_pkg::alu_op_e; OPW must be >= 4)
//   op_a, op_b          - operands; shifts use op_b[4:0] as the shift amount
//   out_valid/out_ready - result handshake
//   result              - registered result, held while out_valid && !out_ready
//   zero                - result == 0
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no operation held, ready to accept
// ST_SHIFT | iterative shift in progress, input stalled, no output
// ST_DONE  | result valid; may accept the next op when out_ready is high
module alu_exec
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int OPW  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  alu_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    state_e             state_q, state_d;
    logic [XLEN-1:0]    result_q, result_d;
    alu_op_e            op_sel;
    logic [XLEN-1:0]    alu_res;
    logic               accept;
    logic               sh_load, sh_step;
    logic [XLEN-1:0]    sh_next;
    logic [SHAMT_W-1:0] sh_cnt;
    logic [SHAMT_W-1:0] shamt;

    // Unused codes fall back to ADD.
    assign op_sel = (alu_op <= OPW'(OP_PASSB)) ? alu_op_e'(alu_op[3:0]) : OP_ADD;
    assign shamt  = op_b[SHAMT_W-1:0];

    always_comb begin
        alu_res = '0;
        case (op_sel)
            OP_ADD:   alu_res = op_a + op_b;
            OP_SUB:   alu_res = op_a - op_b;
            OP_AND:   alu_res = op_a & op_b;
            OP_OR:    alu_res = op_a | op_b;
            OP_XOR:   alu_res = op_a ^ op_b;
            OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            OP_PASSB: alu_res = op_b;
            default:  alu_res = op_a + op_b;
        endcase
    end

    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        sh_load  = 1'b0;
        sh_step  = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if ((state_q == ST_DONE) && out_ready) state_d = ST_IDLE;
                if (accept) begin
                    if (is_shift(op_sel)) begin
                        sh_load = 1'b1;
                        if (shamt == '0) begin
                            result_d = op_a;
                            state_d  = ST_DONE;
                        end else begin
                            state_d  = ST_SHIFT;
                        end
                    end else begin
                        result_d = alu_res;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_SHIFT: begin
                sh_step = 1'b1;
                // Last step: capture the shifter's post-step value directly.
                if (sh_cnt == SHAMT_W'(1)) begin
                    result_d = sh_next;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    alu_iter_shifter #(.XLEN(XLEN)) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (sh_load),
        .step_i  (sh_step),
        .data_i  (op_a),
        .shamt_i (shamt),
        .left_i  (op_sel == OP_SLL),
        .arith_i (op_sel == OP_SRA),
        .next_o  (sh_next),
        .cnt_o   (sh_cnt)
    );

    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = (result_q == '0);

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed self-checking bench for alu_exec.
module tb_alu_exec;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_exec #(.XLEN(32), .OPW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one op for exactly one cycle (must be accepted), then scramble
    // the operand buses to show they are not re-sampled.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        alu_op   = op;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        chk("in_ready_at_issue", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
        alu_op   = 4'($urandom_range(0, 15));
    endtask

    // Single-cycle op: check the result one cycle after accept, then drain.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        issue(op, a, b);
        chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_result"}, result, exp);
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, (exp == 32'd0)});
        tick();
        chk({tag, "_idle"}, {31'd0, out_valid}, 32'd0);
    endtask

    task automatic wait_out(input int budget, output int lat);
        lat = 0;
        while (!out_valid && lat < budget) begin
            tick();
            lat++;
        end
    endtask

    int lat;
    int seen;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        alu_op    = 4'd0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        out_ready = 1'b1;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_release_ready", {31'd0, in_ready}, 32'd1);

        run_op("add_ovf",  4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
        run_op("sub_zero", 4'd1,  32'd5,         32'd5,         32'd0);
        run_op("sub_wrap", 4'd1,  32'd0,         32'd1,         32'hFFFF_FFFF);
        run_op("and",      4'd2,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
        run_op("or",       4'd3,  32'hF000_0000, 32'h0000_000F, 32'hF000_000F);
        run_op("xor",      4'd4,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F);
        run_op("slt",      4'd5,  32'hFFFF_FFFF, 32'h0000_0001, 32'd1);
        run_op("sltu",     4'd6,  32'hFFFF_FFFF, 32'h0000_0001, 32'd0);
        run_op("passb",    4'd10, 32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000);
        run_op("op12_add", 4'd12, 32'd2,         32'd3,         32'd5);
        run_op("op15_add", 4'd15, 32'hFFFF_FFFF, 32'd1,         32'd0);
        run_op("sll_sh0",  4'd7,  32'hCAFE_F00D, 32'h0000_0020, 32'hCAFE_F00D);

        // SLL by 4: latency 1 + 4.
        issue(4'd7, 32'h0000_0001, 32'h0000_0004);
        wait_out(40, lat);
        chk("sll4_lat", lat, 32'd4);
        chk("sll4_result", result, 32'h0000_0010);
        tick();

        // SRL by 4, upper op_b bits must be ignored.
        issue(4'd8, 32'h0000_00F0, 32'hFFFF_FFE4);
        wait_out(40, lat);
        chk("srl4_lat", lat, 32'd4);
        chk("srl4_result", result, 32'h0000_000F);
        tick();

        // SRA by 31 with in_valid held high during SHIFT.
        issue(4'd9, 32'h8000_0000, 32'h0000_001F);
        in_valid = 1'b1;
        alu_op   = 4'd0;
        seen     = 0;
        for (int i = 1; i <= 31; i++) begin
            if (in_ready || out_valid) seen++;
            tick();
        end
        in_valid = 1'b0;
        chk("sra31_shift_stall", seen, 32'd0);
        chk("sra31_valid", {31'd0, out_valid}, 32'd1);
        chk("sra31_result", result, 32'hFFFF_FFFF);
        tick();
        chk("sra31_idle", {31'd0, out_valid}, 32'd0);

        // Backpressure for 3 cycles, then back-to-back accept.
        out_ready = 1'b0;
        issue(4'd0, 32'd1, 32'd2);
        alu_op   = 4'd4;
        op_a     = 32'hAAAA_5555;
        op_b     = 32'hFFFF_0000;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_result", result, 32'd3);
            chk("bp_no_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("b2b_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("b2b_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_result", result, 32'h5555_5555);
        tick();
        chk("b2b_idle", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of an SRL by 10.
        run_op("pre_rst", 4'd3, 32'h0000_0F00, 32'h0000_0000, 32'h0000_0F00);
        issue(4'd8, 32'hFFFF_0000, 32'h0000_000A);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_zero", {31'd0, zero}, 32'd1);
        tick();
        rst_n = 1'b1;
        chk("midrst_ready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) seen++;
            tick();
        end
        chk("midrst_no_valid", seen, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
